// File: rtl/ram_prg_arbiter_if.sv
// Simple single-port RAM style bus shared by the core side and the RAM side
// of ram_prg_arbiter.
interface ram_prg_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output read, output write, output addr, output wdata, input rdata);
  modport slave  (input read, input write, input addr, input wdata, output rdata);
endinterface

// File: rtl/ram_prg_arbiter.sv
// Arbitrates the TinyRAM port between the core bus and the serial programming
// loader; halts the core while a loading session is active.
module ram_prg_arbiter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     prg,
  input  logic                     ser_din,
  input  logic                     ser_clk,
  input  logic                     ser_latch,
  ram_prg_arbiter_if.slave         core,
  ram_prg_arbiter_if.master        ram,
  output logic                     core_halt,
  output logic                     prg_busy,
  output logic [7:0]               prg_count,
  output logic [7:0]               prg_csum,
  output logic                     prg_err
);

  localparam int unsigned WORD_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD, RELEASE} state_t;

  state_t                          state;
  logic [SYNC_STAGES-1:0][3:0]     sync_q;
  logic                            din_s, sclk_s, latch_s, prg_s;
  logic                            sclk_prev, latch_prev;
  logic                            shift_edge, latch_edge;
  logic [WORD_W-1:0]               shreg;
  logic [WORD_W-1:0]               pend_word;
  logic                            pending;
  logic                            busy_q;
  logic                            wr_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [DATA_W-1:0]               data_q;

  assign {prg_s, latch_s, sclk_s, din_s} = sync_q[SYNC_STAGES-1];
  assign shift_edge = sclk_s & ~sclk_prev;
  assign latch_edge = latch_s & ~latch_prev;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= RUN;
      sync_q     <= '0;
      sclk_prev  <= 1'b0;
      latch_prev <= 1'b0;
      shreg      <= '0;
      pend_word  <= '0;
      pending    <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      prg_count  <= '0;
      prg_csum   <= '0;
      prg_err    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], {prg, ser_latch, ser_clk, ser_din}};
      sclk_prev  <= sclk_s;
      latch_prev <= latch_s;
      wr_q       <= 1'b0;

      case (state)
        RUN: begin
          if (prg_s) begin
            state  <= DRAIN;
            busy_q <= 1'b1;
          end
        end
        DRAIN: begin
          prg_err   <= 1'b0;
          prg_count <= '0;
          prg_csum  <= '0;
          shreg     <= '0;
          state     <= LOAD;
        end
        LOAD: begin
          if (shift_edge) shreg <= {shreg[WORD_W-2:0], din_s};
          if (pending && !wr_q) begin
            wr_q      <= 1'b1;
            addr_q    <= pend_word[WORD_W-1 -: ADDR_W];
            data_q    <= pend_word[DATA_W-1:0];
            pending   <= 1'b0;
            prg_count <= prg_count + 8'd1;
            prg_csum  <= prg_csum + 8'(pend_word[DATA_W-1:0]);
          end
          // A latch arriving together with prg falling still gets written
          // before the session closes, so it also blocks the exit.
          if (latch_edge) begin
            pend_word <= shreg;
            pending   <= 1'b1;
          end
          if (!prg_s && !pending && !wr_q && !latch_edge) state <= RELEASE;
        end
        RELEASE: begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
        default: state <= RUN;
      endcase

      if (latch_edge && state != LOAD) prg_err <= 1'b1;
    end
  end

  always_comb begin
    if (state == RUN) begin
      ram.read  = core.read;
      ram.write = core.write;
      ram.addr  = core.addr;
      ram.wdata = core.wdata;
    end else begin
      ram.read  = 1'b0;
      ram.write = wr_q;
      ram.addr  = addr_q;
      ram.wdata = data_q;
    end
  end

  assign core.rdata = ram.rdata;
  assign core_halt  = busy_q;
  assign prg_busy   = busy_q;

endmodule

// File: tb/tb_ram_prg_arbiter.sv
// Directed bench for ram_prg_arbiter with a behavioural RAM on the RAM port.
module tb_ram_prg_arbiter;

  logic       clk = 1'b0;
  logic       nreset, prg, ser_din, ser_clk, ser_latch;
  logic       core_halt, prg_busy, prg_err;
  logic [7:0] prg_count, prg_csum;

  always #5 clk = ~clk;

  ram_prg_arbiter_if #(.ADDR_W(8), .DATA_W(8)) core_if ();
  ram_prg_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ram_if ();

  ram_prg_arbiter #(.SYNC_STAGES(3), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .prg       (prg),
    .ser_din   (ser_din),
    .ser_clk   (ser_clk),
    .ser_latch (ser_latch),
    .core      (core_if),
    .ram       (ram_if),
    .core_halt (core_halt),
    .prg_busy  (prg_busy),
    .prg_count (prg_count),
    .prg_csum  (prg_csum),
    .prg_err   (prg_err)
  );

  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) if (ram_if.write) mem[ram_if.addr] <= ram_if.wdata;
  assign ram_if.rdata = mem[ram_if.addr];

  logic [15:0] wlog [$];
  always @(negedge clk) if (nreset && ram_if.write) wlog.push_back({ram_if.addr, ram_if.wdata});

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic val, input string name);
    int unsigned k = 0;
    while (prg_busy !== val && k < 50) begin
      tick(1);
      k++;
    end
    check(name, prg_busy, val);
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      ser_din = w[i];
      tick(1);
      ser_clk = 1'b1;
      tick(2);
      ser_clk = 1'b0;
      tick(2);
    end
  endtask

  task automatic latch_pulse();
    ser_latch = 1'b1;
    tick(2);
    ser_latch = 1'b0;
    tick(2);
  endtask

  initial begin
    int unsigned lat, viol, k;
    logic found;

    vecs[0] = '{1'b0, 1'b1, 8'h20, 8'h5A, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[2] = '{1'b0, 1'b1, 8'h21, 8'hC3, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h21, 8'h00, 8'hC3};
    vecs[4] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[5] = '{1'b0, 1'b0, 8'h22, 8'h77, 8'h00};

    nreset = 1'b0; prg = 1'b0; ser_din = 1'b0; ser_clk = 1'b0; ser_latch = 1'b0;
    core_if.read = 1'b0; core_if.write = 1'b0; core_if.addr = '0; core_if.wdata = '0;
    tick(2);
    check("rst core_halt", core_halt, 1'b0);
    check("rst prg_busy", prg_busy, 1'b0);
    check("rst prg_count", prg_count, 8'h00);
    check("rst prg_csum", prg_csum, 8'h00);
    check("rst prg_err", prg_err, 1'b0);
    check("rst ram_write", ram_if.write, 1'b0);
    nreset = 1'b1;
    tick(2);

    // Core pass-through in RUN
    for (int i = 0; i < 6; i++) begin
      core_if.read  = vecs[i].rd;
      core_if.write = vecs[i].wr;
      core_if.addr  = vecs[i].addr;
      core_if.wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d ram_read", i), ram_if.read, vecs[i].rd);
      check($sformatf("vec%0d ram_write", i), ram_if.write, vecs[i].wr);
      check($sformatf("vec%0d ram_addr", i), ram_if.addr, vecs[i].addr);
      check($sformatf("vec%0d ram_wdata", i), ram_if.wdata, vecs[i].wdata);
      check($sformatf("vec%0d core_rdata", i), core_if.rdata, vecs[i].exp_rdata);
      tick(1);
    end
    core_if.read = 1'b0; core_if.write = 1'b0;

    // Stray latch outside a session
    wlog.delete();
    latch_pulse();
    tick(4);
    check("stray latch err", prg_err, 1'b1);
    check("stray latch no write", wlog.size(), 0);
    check("stray latch busy", prg_busy, 1'b0);

    // Three-word programming session
    wlog.delete();
    prg = 1'b1;
    wait_busy(1'b1, "session enter busy");
    check("session core_halt", core_halt, 1'b1);
    tick(3);
    check("drain clears err", prg_err, 1'b0);
    check("drain clears count", prg_count, 8'h00);
    shift_word(16'h1055); latch_pulse();
    shift_word(16'h11AA); latch_pulse();
    shift_word(16'h12FF); latch_pulse();
    tick(6);
    prg = 1'b0;
    wait_busy(1'b0, "session leave busy");
    check("session halt released", core_halt, 1'b0);
    check("session count", prg_count, 8'd3);
    check("session csum", prg_csum, 8'hFE);
    check("session writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("write0", wlog[0], 16'h1055);
      check("write1", wlog[1], 16'h11AA);
      check("write2", wlog[2], 16'h12FF);
    end
    core_if.read = 1'b1; core_if.addr = 8'h11;
    #1;
    check("core reads loaded", core_if.rdata, 8'hAA);
    core_if.read = 1'b0;
    tick(5);
    check("count held in RUN", prg_count, 8'd3);
    check("csum held in RUN", prg_csum, 8'hFE);

    // Latch together with prg fall; latency from pin to ram_write
    wlog.delete();
    prg = 1'b1;
    wait_busy(1'b1, "lat enter busy");
    tick(2);
    shift_word(16'h3077);
    core_if.read = 1'b1; core_if.addr = 8'h40;
    ser_latch = 1'b1;
    prg = 1'b0;
    found = 1'b0; lat = 0; viol = 0;
    for (int e = 1; e <= 12 && !found; e++) begin
      tick(1);
      if (ram_if.read) viol++;
      if (ram_if.write) begin found = 1'b1; lat = e; end
    end
    check("latch latency", lat, 5);
    check("late write addr", ram_if.addr, 8'h30);
    check("late write data", ram_if.wdata, 8'h77);
    tick(1);
    check("late write single", ram_if.write, 1'b0);
    ser_latch = 1'b0;
    k = 0;
    while (prg_busy && k < 20) begin
      if (ram_if.read || ram_if.write) viol++;
      tick(1);
      k++;
    end
    check("late leave busy", prg_busy, 1'b0);
    check("no core grant while busy", viol, 0);
    check("core granted after", ram_if.read, 1'b1);
    check("late log", wlog.size(), 1);
    if (wlog.size() == 1) check("late log word", wlog[0], 16'h3077);
    core_if.read = 1'b0;
    tick(2);

    // Reset in the middle of LOAD
    prg = 1'b1;
    wait_busy(1'b1, "rstload enter busy");
    tick(2);
    shift_word(16'h5011);
    latch_pulse();
    tick(4);
    check("rstload count before", prg_count, 8'd1);
    #2;
    nreset = 1'b0;
    #1;
    check("rstload core_halt", core_halt, 1'b0);
    check("rstload prg_busy", prg_busy, 1'b0);
    check("rstload count", prg_count, 8'h00);
    check("rstload csum", prg_csum, 8'h00);
    check("rstload err", prg_err, 1'b0);
    check("rstload ram_write", ram_if.write, 1'b0);
    prg = 1'b0;
    tick(2);
    nreset = 1'b1;
    tick(4);
    check("rstload stays RUN", prg_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_prg_arbiter.md
Name: ram_prg_arbiter

Overview:
- Owns the single TinyRAM port and arbitrates it between the TinyCore bus and the serial programming loader.
- Synchronizes the asynchronous programming pins (din, shift clock, latch, prg) into clk, assembles 16-bit {addr,data} words and issues RAM writes.
- Halts the core while loading and reports word count, checksum and protocol errors.
- Replaces the open-coded prg muxing and the free-running shift register in the SoC top.

Parameters:
- SYNC_STAGES, 2, flops per synchronizer chain on ser_din/ser_clk/ser_latch/prg (min 2)
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- prg  in  1  async program-mode request
- ser_din  in  1  async serial data
- ser_clk  in  1  async shift clock; rising edge samples ser_din
- ser_latch  in  1  async latch; rising edge commits shifted word
- core_read  in  1  core read strobe
- core_write  in  1  core write strobe
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_rdata  out  DATA_W  = ram_rdata (combinational)
- core_halt  out  1  1 = core clock must be gated off
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- prg_busy  out  1  1 in any state other than RUN
- prg_count  out  8  words written this session, wraps 0xFF->0x00
- prg_csum  out  8  mod-256 sum of data bytes written this session
- prg_err  out  1  sticky latch-outside-LOAD error

Behaviour:
- Reset (async, nreset=0): state RUN; shift reg, pending, count, csum, err, all sync flops = 0; core_halt=0, prg_busy=0, ram_write=0. Reset mid-LOAD aborts the session immediately.
- Sync: each async input passes through SYNC_STAGES flops. Edge detect: registered copy, edge = sync & ~prev.
- Shift: on ser_clk edge in LOAD only, shreg <= {shreg[14:0], din_sync}, MSB first. Word = {addr=shreg[15:8], data=shreg[7:0]}. Shift edges outside LOAD are ignored.
- Latch edge in LOAD: pend_word <= shreg, pending <= 1. Latch edge in any other state: word dropped, prg_err <= 1.
- FSM:
  - RUN: ram_* = core_* (combinational pass-through); core_halt=0. prg_sync=1 -> DRAIN.
  - DRAIN (1 cycle): core_halt=1, ram_read=ram_write=0; clear err, count, csum, shreg -> LOAD.
  - LOAD: core_halt=1, ram_read=0. If pending: next cycle ram_write=1 for exactly one cycle with ram_addr/ram_wdata = pend_word; pending cleared; count += 1; csum += data. Once prg_sync=0 and no write is pending or in flight -> RELEASE.
  - RELEASE (1 cycle): core_halt=1, RAM idle -> RUN. core_halt deasserts on entry to RUN.
- Latency: the pin ser_latch rise produces ram_write exactly SYNC_STAGES+2 clk edges later.
- ram_addr and ram_wdata are held stable while ram_write=1. In LOAD they otherwise hold the last value.
- Simultaneous latch edge and prg fall: the word is accepted and written before RELEASE.
- Simultaneous shift edge and latch edge: the latch captures shreg before that shift.
- prg toggling during DRAIN or RELEASE: the current state finishes, then the FSM re-evaluates.
- count and csum hold their values in RUN until the next DRAIN.

Test Plan:
- Assert nreset=0 mid-LOAD after 1 word -> core_halt=0, prg_busy=0, prg_count=0, prg_err=0, ram_write=0 immediately (async).
- prg=1; shift and latch 0x1055, 0x11AA, 0x12FF; prg=0 -> three single-cycle writes (0x10,0x55), (0x11,0xAA), (0x12,0xFF); prg_count=3, prg_csum=0xFE; core_halt falls 1 cycle after RELEASE.
- RUN: core_write=1, addr=0x20, wdata=0x5A, then core_read addr 0x20 -> ram_* mirror core signals the same cycle; core_rdata=0x5A.
- prg=0; pulse ser_latch -> no ram_write, prg_err=1. Next prg session -> prg_err cleared in DRAIN.
- Latch 0x3077 and drop prg in the same cycle -> write (0x30,0x77) occurs, then RELEASE, RUN; no core access is granted before the write.
- Latency check with SYNC_STAGES=3: ser_latch rise at pin -> ram_write high exactly 5 clk edges later, for 1 cycle.
